lsu_stage: RTL

LSU_STAGE -- requirements
Module: lsu_stage

---
 rtl/lsu_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lsu_stage.sv
// Load/store pipeline stage: EX/MEM register, one-cycle byte-lane memory
// access, alignment/funct3 checking and a registered MEM/WB output.
module lsu_stage #(
  parameter bit          MISALIGN_TRAP = 1'b1,
  localparam int unsigned XLEN = 32,
  localparam int unsigned RW   = 5,
  localparam int unsigned F3W  = 3,
  localparam int unsigned CW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_load,
  input  logic            ex_store,
  input  logic [F3W-1:0]  ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [RW-1:0]   ex_rd,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            stall,
  input  logic            flush,
  output logic            mem_we,
  output logic [F3W-1:0]  mem_mode,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_wen,
  output logic            exc,
  output logic [CW-1:0]   exc_cause,
  output logic [XLEN-1:0] exc_addr
);

  // EX/MEM register
  logic            valid_q, valid_d;
  logic            load_q, load_d;
  logic            store_q, store_d;
  logic [F3W-1:0]  f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            sdone_q, sdone_d;

  // MEM/WB register
  logic            wb_valid_q, wb_valid_d;
  logic [RW-1:0]   wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_wen_q, wb_wen_d;
  logic            exc_q, exc_d;
  logic [CW-1:0]   exc_cause_q, exc_cause_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;

  logic            mem_op, is_half, is_word, bad_f3, misalign, fault;
  logic [CW-1:0]   cause;
  logic [XLEN-1:0] load_res;

  // Decode the held instruction: size, fault classification, memory drive
  always_comb begin
    mem_op    = valid_q & (load_q | store_q);
    is_half   = (f3_q[1:0] == 2'b01);
    is_word   = (f3_q[1:0] == 2'b10);
    bad_f3    = mem_op & ((f3_q == 3'b011) | (f3_q[2:1] == 2'b11));
    misalign  = MISALIGN_TRAP & mem_op & ~bad_f3 &
                ((is_half & addr_q[0]) | (is_word & (addr_q[1:0] != 2'b00)));
    fault     = bad_f3 | misalign;
    cause     = bad_f3 ? 2'b10 : (misalign ? 2'b01 : 2'b00);

    mem_addr  = addr_q;
    mem_we    = valid_q & store_q & ~fault & ~sdone_q;
    case (f3_q[1:0])
      2'b00:   begin mem_mode = 3'b001; mem_wdata = {4{rs2_q[7:0]}};  end
      2'b01:   begin mem_mode = 3'b010; mem_wdata = {2{rs2_q[15:0]}}; end
      2'b10:   begin mem_mode = 3'b100; mem_wdata = rs2_q;            end
      default: begin mem_mode = 3'b000; mem_wdata = rs2_q;            end
    endcase

    // Memory sign-extends; unsigned loads strip the upper bits here
    case (f3_q)
      3'b100:  load_res = {24'b0, mem_rdata[7:0]};
      3'b101:  load_res = {16'b0, mem_rdata[15:0]};
      default: load_res = mem_rdata;
    endcase
  end

  // Next-state for both pipeline registers
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    store_d = store_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    wdata_d = wdata_q;
    sdone_d = sdone_q;

    if (flush) begin
      valid_d = 1'b0;
      sdone_d = 1'b0;
    end else if (!stall) begin
      valid_d = ex_valid;
      load_d  = ex_load;
      store_d = ex_store;
      f3_d    = ex_funct3;
      addr_d  = ex_addr;
      rs2_d   = ex_rs2;
      rd_d    = ex_rd;
      wdata_d = ex_wdata;
      sdone_d = 1'b0;
    end else if (mem_we) begin
      // Held store already wrote; block repeats while stalled
      sdone_d = 1'b1;
    end

    wb_valid_d  = valid_q & ~stall;
    wb_rd_d     = rd_q;
    wb_data_d   = (load_q & ~store_q) ? load_res : wdata_q;
    wb_wen_d    = valid_q & ~store_q & ~fault & (rd_q != 5'd0) & ~stall;
    exc_d       = fault & ~stall;
    exc_cause_d = exc_d ? cause : 2'b00;
    exc_addr_d  = exc_d ? addr_q : 32'd0;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= 32'd0;
      rs2_q       <= 32'd0;
      rd_q        <= 5'd0;
      wdata_q     <= 32'd0;
      sdone_q     <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'd0;
      wb_wen_q    <= 1'b0;
      exc_q       <= 1'b0;
      exc_cause_q <= 2'b00;
      exc_addr_q  <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      load_q      <= load_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      sdone_q     <= sdone_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_wen_q    <= wb_wen_d;
      exc_q       <= exc_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_wen    = wb_wen_q;
  assign exc       = exc_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;

endmodule
